// File: rtl/gate_pkg.sv
// Shared definitions for the gate library: op encoding and the bitwise evaluator.
package gate_pkg;

  typedef logic [2:0] gate_op_t;

  localparam gate_op_t OP_AND     = 3'b000;
  localparam gate_op_t OP_OR      = 3'b001;
  localparam gate_op_t OP_XOR     = 3'b010;
  localparam gate_op_t OP_NAND    = 3'b011;
  localparam gate_op_t OP_NOR     = 3'b100;
  localparam gate_op_t OP_XNOR    = 3'b101;
  localparam gate_op_t OP_NOT_A   = 3'b110;
  localparam gate_op_t OP_ILLEGAL = 3'b111;

  // The evaluator works on the widest supported word; callers truncate.
  localparam int GATE_MAX_W = 64;
  typedef logic [GATE_MAX_W-1:0] gate_word_t;

  // err sits in the LSB so that a truncating cast to WIDTH+1 bits yields
  // {y[WIDTH-1:0], err} directly.
  typedef struct packed {
    gate_word_t y;
    logic       err;
  } gate_res_t;

  function automatic gate_res_t gate_eval(gate_word_t a, gate_word_t b, gate_op_t op);
    gate_res_t r;
    r.y   = '0;
    r.err = 1'b0;
    case (op)
      OP_AND:   r.y = a & b;
      OP_OR:    r.y = a | b;
      OP_XOR:   r.y = a ^ b;
      OP_NAND:  r.y = ~(a & b);
      OP_NOR:   r.y = ~(a | b);
      OP_XNOR:  r.y = ~(a ^ b);
      OP_NOT_A: r.y = ~a;
      default: begin
        r.y   = '0;
        r.err = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_fifo.sv
// Circular result buffer with valid/ready on both sides.
// in_ready depends only on registered occupancy, never on out_ready.
module gate_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset; buffered entries are discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; writes are blocked during reset anyway.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/gate_alu_pipe.sv
// WIDTH-bit bitwise gate unit feeding an elastic result buffer,
// with gated head outputs and a saturating delivered-result counter.
module gate_alu_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             op_err,
  output logic [CNT_W-1:0] result_count
);

  logic [WIDTH:0]   push_data;
  logic [WIDTH:0]   head_data;
  logic             fifo_out_valid;
  logic             pop;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Entry layout is {y, err}; the cast drops the unused upper result bits.
  assign push_data = (WIDTH+1)'(gate_eval(GATE_MAX_W'(a), GATE_MAX_W'(b), gate_op_t'(op)));

  gate_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (push_data),
    .out_valid (fifo_out_valid),
    .out_ready (out_ready),
    .out_data  (head_data)
  );

  assign out_valid = fifo_out_valid;
  assign y         = fifo_out_valid ? head_data[WIDTH:1] : '0;
  assign op_err    = fifo_out_valid & head_data[0];
  assign pop       = fifo_out_valid && out_ready;

  // Count delivered results, holding at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (pop && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign result_count = cnt_q;

endmodule

// File: tb/tb_gate_alu_pipe.sv
module tb_gate_alu_pipe;
  import gate_pkg::*;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, op_err;
  logic [W-1:0]  a, b, y;
  logic [2:0]    op;
  logic [CW-1:0] result_count;

  logic          in_valid2, in_ready2, out_valid2, out_ready2, op_err2;
  logic [W-1:0]  a2, b2, y2;
  logic [2:0]    op2;
  logic [1:0]    result_count2;

  gate_alu_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .op_err(op_err), .result_count(result_count)
  );

  gate_alu_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .op(op2), .out_valid(out_valid2), .out_ready(out_ready2),
    .y(y2), .op_err(op_err2), .result_count(result_count2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of pending results plus delivered counts.
  typedef struct { logic [W-1:0] y; logic err; } ent_t;
  ent_t mq[$];
  int   mrc  = 0;
  int   mq2  = 0;
  int   mrc2 = 0;

  // Compare all outputs against the model, advance one clock, update the model.
  task automatic cycle();
    bit        push, pop, push2, pop2;
    gate_res_t r;
    ent_t      e;
    chk("out_valid", out_valid, mq.size() != 0);
    chk("in_ready", in_ready, mq.size() < D);
    chk("y", y, (mq.size() != 0) ? mq[0].y : 8'h00);
    chk("op_err", op_err, (mq.size() != 0) ? mq[0].err : 1'b0);
    chk("result_count", result_count, mrc);
    chk("sat_out_valid", out_valid2, mq2 != 0);
    chk("sat_result_count", result_count2, mrc2);
    push  = in_valid && (mq.size() < D);
    pop   = out_ready && (mq.size() != 0);
    push2 = in_valid2 && (mq2 < D);
    pop2  = out_ready2 && (mq2 != 0);
    r     = gate_eval(64'(a), 64'(b), op);
    e.y   = r.y[W-1:0];
    e.err = r.err;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      mrc  = 0;
      mq2  = 0;
      mrc2 = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        if (mrc < 65535) mrc++;
      end
      if (push) mq.push_back(e);
      if (pop2) begin
        mq2--;
        if (mrc2 < 3) mrc2++;
      end
      if (push2) mq2++;
    end
    #1;
  endtask

  typedef struct { logic [2:0] op; logic [7:0] y; logic err; } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{3'd0, 8'hC0, 1'b0};
    tbl[1] = '{3'd1, 8'hFC, 1'b0};
    tbl[2] = '{3'd2, 8'h3C, 1'b0};
    tbl[3] = '{3'd3, 8'h3F, 1'b0};
    tbl[4] = '{3'd4, 8'h03, 1'b0};
    tbl[5] = '{3'd5, 8'hC3, 1'b0};
    tbl[6] = '{3'd6, 8'h0F, 1'b0};
    tbl[7] = '{3'd7, 8'h00, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = 8'h5A; b2 = 8'h0F; op2 = OP_XOR;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_y", y, 0);
    chk("rst_op_err", op_err, 0);
    chk("rst_count", result_count, 0);

    // 1: op sweep with a free-running consumer
    out_ready = 1'b1;
    a = 8'hF0; b = 8'hCC;
    for (int i = 0; i <= 8; i++) begin
      in_valid = (i < 8);
      op = 3'(i);
      if (i > 0) begin
        chk("sweep_valid", out_valid, 1);
        chk("sweep_y", y, tbl[i-1].y);
        chk("sweep_err", op_err, tbl[i-1].err);
      end
      cycle();
    end
    in_valid = 1'b0;
    chk("sweep_count", result_count, 8);
    cycle();

    // 2: backpressure fill, third operand held
    out_ready = 1'b0; in_valid = 1'b1; op = OP_OR; b = 8'h00;
    a = 8'h11; cycle();
    a = 8'h22; cycle();
    a = 8'h33;
    chk("bp_full_ready", in_ready, 0);
    cycle();
    chk("bp_held_ready", in_ready, 0);
    out_ready = 1'b1;
    chk("bp_head0", y, 8'h11);
    cycle();
    chk("bp_ready_after_pop", in_ready, 1);
    chk("bp_head1", y, 8'h22);
    cycle();
    in_valid = 1'b0;
    chk("bp_head2", y, 8'h33);
    cycle();
    cycle();

    // 3: concurrent push and pop at occupancy 1
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h40;
    cycle();
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      a = 8'(8'h40 + k);
      chk("cc_valid", out_valid, 1);
      chk("cc_y", y, 8'(8'h40 + k - 1));
      chk("cc_ready", in_ready, 1);
      cycle();
    end
    in_valid = 1'b0;
    chk("cc_last", y, 8'h45);
    cycle();

    // 4: saturation with a 2-bit counter
    in_valid2 = 1'b1; out_ready2 = 1'b1;
    repeat (5) cycle();
    in_valid2 = 1'b0;
    repeat (2) cycle();
    chk("sat_count", result_count2, 3);

    // 5: reset with two entries buffered; push/pop in the reset cycle ignored
    out_ready = 1'b0; in_valid = 1'b1; op = OP_OR; b = 8'h00;
    a = 8'h55; cycle();
    a = 8'h66; cycle();
    rst_n = 1'b0; out_ready = 1'b1; a = 8'h77;
    @(posedge clk);
    mq.delete(); mrc = 0; mq2 = 0; mrc2 = 0;
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_y", y, 0);
    chk("mrst_op_err", op_err, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_count", result_count, 0);
    chk("mrst_sat_count", result_count2, 0);
    repeat (3) cycle();

    // 6: idle inputs toggling
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      chk("idle_valid", out_valid, 0);
      chk("idle_y", y, 0);
      cycle();
    end

    // Randomised traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      rst_n      = ($urandom_range(0, 63) != 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      a          = 8'($urandom);
      b          = 8'($urandom);
      op         = 3'($urandom);
      in_valid2  = $urandom_range(0, 1) == 1;
      out_ready2 = $urandom_range(0, 1) == 1;
      cycle();
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
